// File: rtl/e_mul_div_unit.sv
// E-stage multi-cycle multiply/divide unit. The result is computed into pending HI/LO
// when the op is accepted. It commits to the architectural registers after a fixed latency.
module e_mul_div_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_mdOp,
    input  logic [WIDTH-1:0] i_srcA,
    input  logic [WIDTH-1:0] i_srcB,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    md_op_e w_op;
    logic   w_is_mul;
    logic   w_is_div;
    logic   w_signed;

    assign w_op     = md_op_e'(i_mdOp);
    assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_is_div = (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

    // One 2W-bit multiplier serves both flavours: with sign-extended operands the
    // product modulo 2^(2W) is the signed product.
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_ext_a = {{WIDTH{w_signed & i_srcA[WIDTH-1]}}, i_srcA};
    assign w_ext_b = {{WIDTH{w_signed & i_srcB[WIDTH-1]}}, i_srcB};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide runs on magnitudes. |MIN| fits unsigned, so MIN/-1 yields MIN rem 0.
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_dsr;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_neg_a    = w_signed & i_srcA[WIDTH-1];
    assign w_neg_b    = w_signed & i_srcB[WIDTH-1];
    assign w_mag_a    = w_neg_a ? (~i_srcA + WIDTH'(1)) : i_srcA;
    assign w_mag_b    = w_neg_b ? (~i_srcB + WIDTH'(1)) : i_srcB;
    assign w_div_zero = (i_srcB == '0);
    assign w_dsr      = w_div_zero ? WIDTH'(1) : w_mag_b;
    assign w_quo      = w_mag_a / w_dsr;
    assign w_rem      = w_mag_a % w_dsr;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_res_we;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_we = 1'b0;
        if (w_is_mul) begin
            {w_res_hi, w_res_lo} = w_prod;
            w_res_we             = 1'b1;
        end else if (w_is_div) begin
            w_res_lo = (w_neg_a ^ w_neg_b) ? (~w_quo + WIDTH'(1)) : w_quo;
            w_res_hi = w_neg_a ? (~w_rem + WIDTH'(1)) : w_rem;
            w_res_we = !w_div_zero;
        end
    end

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: pending regs are reset too, so an aborted op can never commit stale data.
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; every register reads pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_is_mul || w_is_div) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_pend_we <= w_res_we;
                            r_cnt     <= w_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                            r_busy    <= 1'b1;
                            r_state   <= ST_BUSY;
                        end else if (w_op == OP_MTHI) begin
                            r_hi <= i_srcA;
                        end else if (w_op == OP_MTLO) begin
                            r_lo <= i_srcA;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: tb/tb_e_mul_div_unit.sv
// Self-checking bench for e_mul_div_unit: directed cases plus randomized ops.
// Expected values come from a plain-arithmetic HI/LO model.
module tb_e_mul_div_unit;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [2:0]       i_mdOp;
    logic [WIDTH-1:0] i_srcA;
    logic [WIDTH-1:0] i_srcB;
    logic             o_busy;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mul_div_unit #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_mdOp (i_mdOp),
        .i_srcA (i_srcA),
        .i_srcB (i_srcB),
        .o_busy (o_busy),
        .o_hi   (o_hi),
        .o_lo   (o_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, {32'd0, o_hi}, {32'd0, m_hi});
        check({tag, "_lo"}, {32'd0, o_lo}, {32'd0, m_lo});
    endtask

    // Architectural effect of one accepted op, straight from the arithmetic rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            MULT: begin
                sp   = longint'(sa) * longint'(sb);
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MULTU: begin
                up   = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            DIV: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            DIVU: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            default: begin
            end
        endcase
    endtask

    // Caller is at a negedge; the op is accepted at the following posedge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject_mthi);
        int lat;
        lat = (op == MULT || op == MULTU) ? MUL_LAT : DIV_LAT;
        model(op, a, b);
        i_start = 1'b1;
        i_mdOp  = op;
        i_srcA  = a;
        i_srcB  = b;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
            if (inject_mthi && i == 1) begin
                i_start = 1'b1;
                i_mdOp  = MTHI;
                i_srcA  = 32'hDEAD_BEEF;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        check({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
        check_regs(tag);
    endtask

    // Ops that complete in one edge or have no effect at all.
    task automatic run_quick(input string tag, input bit start, input logic [2:0] op,
                             input logic [31:0] a);
        if (start) model(op, a, 32'd0);
        i_start = start;
        i_mdOp  = op;
        i_srcA  = a;
        i_srcB  = 32'd5;
        @(negedge i_clk);
        i_start = 1'b0;
        check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        check_regs(tag);
    endtask

    function automatic logic [31:0] pick(input logic [31:0] special);
        case ($urandom_range(0, 3))
            0:       return special;
            1:       return 32'($urandom_range(0, 50));
            2:       return -32'($urandom_range(1, 50));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_mdOp  = NONE;
        i_srcA  = '0;
        i_srcB  = '0;
        m_hi    = '0;
        m_lo    = '0;
        #2;
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check_regs("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_op("t1_mult", MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("t1_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("t2_multu", MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("t2_const", {o_hi, o_lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("t3_div", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("t3_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("t3_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("t3_ovf_const", {o_hi, o_lo}, 64'h0000_0000_8000_0000);

        run_quick("t4_mthi", 1'b1, MTHI, 32'h11);
        run_quick("t4_mtlo", 1'b1, MTLO, 32'h22);
        run_op("t4_divu0", DIVU, 32'd1234, 32'd0, 1'b1);
        check("t4_const", {o_hi, o_lo}, 64'h0000_0011_0000_0022);
        run_quick("t4_none", 1'b1, NONE, 32'h5555);
        run_quick("t4_rsvd", 1'b1, RSVD, 32'h6666);
        run_quick("t4_nostart", 1'b0, MTHI, 32'h7777);

        // Reset in flight: outputs clear asynchronously and the aborted mult never lands.
        run_op("t5_pre", MULTU, 32'd9, 32'd9, 1'b0);
        i_start = 1'b1;
        i_mdOp  = MULT;
        i_srcA  = 32'd1000;
        i_srcB  = 32'd1000;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("t5_rst_busy", {63'd0, o_busy}, 64'd0);
        check_regs("t5_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("t5_after", MULT, 32'd3, 32'd4, 1'b0);

        run_op("t6_divu", DIVU, 32'd100, 32'd7, 1'b0);
        check("t6_divu_const", {o_hi, o_lo}, 64'h0000_0002_0000_000E);
        run_op("t6_multu", MULTU, 32'd6, 32'd7, 1'b0);
        check("t6_multu_const", {o_hi, o_lo}, 64'h0000_0000_0000_002A);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick(32'h8000_0000);
            b  = pick(($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF);
            if (op >= MULT && op <= DIVU) run_op("rnd_md", op, a, b, 1'b0);
            else run_quick("rnd_misc", 1'b1, op, a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
